// File: rtl/instruction_fetch_b2b_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package instruction_fetch_b2b_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitBlk = 3'd1,
    StFetch   = 3'd2,
    StDrain   = 3'd3,
    StDone    = 3'd4
  } fetch_state_e;

  // Width able to hold 0..depth inclusive (FIFO occupancy, outstanding reads).
  function automatic int unsigned occ_width(input int unsigned depth);
    return unsigned'($clog2(depth)) + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO with clear; head is forced to zero while empty.
module inst_fetch_fifo
  import instruction_fetch_b2b_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = occ_width(Depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = unsigned'($clog2(Depth));
  localparam logic [CntW-1:0] DepthC = Depth[CntW-1:0];

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == DepthC);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = cnt_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage write; no reset needed since the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy tracking; clear dominates any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_b2b.sv
// Instruction fetch: credit-limited block reads from imem into a decoder-facing FIFO.
module instruction_fetch_b2b
  import instruction_fetch_b2b_pkg::*;
#(
  parameter int unsigned INST_DATA_WIDTH = 32,
  parameter int unsigned INST_ADDR_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [INST_ADDR_WIDTH:0]   block_num_inst,
  input  logic                       last_block,
  input  logic                       flush,
  input  logic                       imem_block_ready,
  output logic                       imem_rd_req,
  output logic [INST_ADDR_WIDTH-1:0] imem_rd_addr,
  input  logic [INST_DATA_WIDTH-1:0] imem_rd_data,
  input  logic                       imem_rd_valid,
  output logic                       imem_rd_block_done,
  output logic [INST_DATA_WIDTH-1:0] inst_data,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic                       fetch_busy,
  output logic                       ovf_err
);

  localparam int unsigned CntW = occ_width(FIFO_DEPTH);
  localparam int unsigned NW   = INST_ADDR_WIDTH + 1;
  localparam logic [CntW:0] DepthLim = FIFO_DEPTH[CntW:0];

  fetch_state_e               state_q;
  logic [NW-1:0]              n_q, rd_ptr_q, rd_ptr_next;
  logic                       lb_q, discard_q, req_q, done_q, ovf_q;
  logic [INST_ADDR_WIDTH-1:0] addr_q;
  logic [CntW-1:0]            outs_q, outs_next;

  logic [CntW-1:0] fifo_count;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_clear;
  logic            ret, issue, room;
  logic [CntW:0]   used;

  assign fifo_pop   = !fifo_empty && inst_ready;
  // Returns only count while reads are outstanding, so stale data after reset is dropped.
  assign ret        = imem_rd_valid && (outs_q != '0);
  assign fifo_push  = ret && !discard_q;
  assign fifo_clear = flush && (state_q != StIdle);
  // A slot popped this cycle is already free for the next request.
  assign used       = {1'b0, fifo_count} + {1'b0, outs_q} - {{CntW{1'b0}}, fifo_pop};
  assign room       = used < DepthLim;

  // Decide whether a read request is launched for the next cycle.
  always_comb begin
    issue = 1'b0;
    case (state_q)
      StWaitBlk: issue = imem_block_ready && (block_num_inst != '0) && room;
      StFetch:   issue = !flush && (rd_ptr_q < n_q) && room;
      default:   issue = 1'b0;
    endcase
  end

  assign outs_next   = outs_q + CntW'(issue) - CntW'(ret);
  assign rd_ptr_next = rd_ptr_q + NW'(issue);

  // Fetch FSM with registered request/done outputs and outstanding-read tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      n_q       <= '0;
      rd_ptr_q  <= '0;
      lb_q      <= 1'b0;
      discard_q <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      outs_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      outs_q <= outs_next;
      req_q  <= issue;
      done_q <= 1'b0;
      if (fifo_push && fifo_full && !fifo_pop && !fifo_clear) ovf_q <= 1'b1;
      case (state_q)
        StIdle: if (start) state_q <= StWaitBlk;
        StWaitBlk: begin
          if (imem_block_ready) begin
            n_q      <= block_num_inst;
            lb_q     <= last_block;
            addr_q   <= '0;
            rd_ptr_q <= NW'(issue);
            if (block_num_inst == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StFetch: begin
          if (flush) begin
            if (outs_next == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q   <= StDrain;
              discard_q <= 1'b1;
            end
          end else begin
            if (issue) addr_q <= rd_ptr_q[INST_ADDR_WIDTH-1:0];
            rd_ptr_q <= rd_ptr_next;
            if (rd_ptr_next == n_q) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (outs_next == '0) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            discard_q <= 1'b0;
          end
        end
        StDone:  state_q <= lb_q ? StIdle : StWaitBlk;
        default: state_q <= StIdle;
      endcase
    end
  end

  inst_fetch_fifo #(
    .Width (INST_DATA_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .wdata_i (imem_rd_data),
    .pop_i   (fifo_pop),
    .rdata_o (inst_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign imem_rd_req        = req_q;
  assign imem_rd_addr       = addr_q;
  assign imem_rd_block_done = done_q;
  assign inst_valid         = !fifo_empty;
  assign fetch_busy         = (state_q != StIdle);
  assign ovf_err            = ovf_q;

endmodule

// File: tb/tb_instruction_fetch_b2b.sv
// Scoreboard bench for instruction_fetch_b2b with a latency-programmable memory model.
module tb_instruction_fetch_b2b;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, start, last_block, flush, imem_block_ready;
  logic [AW:0]   block_num_inst;
  logic          imem_rd_req, imem_rd_valid, imem_rd_block_done;
  logic [AW-1:0] imem_rd_addr;
  logic [DW-1:0] imem_rd_data, inst_data;
  logic          inst_valid, inst_ready, fetch_busy, ovf_err;

  always #5 clk = ~clk;

  instruction_fetch_b2b #(
    .INST_DATA_WIDTH (DW),
    .INST_ADDR_WIDTH (AW),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .block_num_inst     (block_num_inst),
    .last_block         (last_block),
    .flush              (flush),
    .imem_block_ready   (imem_block_ready),
    .imem_rd_req        (imem_rd_req),
    .imem_rd_addr       (imem_rd_addr),
    .imem_rd_data       (imem_rd_data),
    .imem_rd_valid      (imem_rd_valid),
    .imem_rd_block_done (imem_rd_block_done),
    .inst_data          (inst_data),
    .inst_valid         (inst_valid),
    .inst_ready         (inst_ready),
    .fetch_busy         (fetch_busy),
    .ovf_err            (ovf_err)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  int            total = 0;
  int            bad = 0;
  int            n_req = 0;
  int            done_cnt = 0;
  int            cyc = 0;
  int            lat = 2;
  logic [7:0]    blk_tag = 8'h00;
  pend_t         pend[$];
  logic [AW-1:0] got_addr[$];
  int            got_cyc[$];
  logic [31:0]   exp_q[$];

  function automatic logic [31:0] mem_word(input logic [7:0] tag, input int a);
    return {tag, 8'h00, 6'd0, a[9:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Memory model: in-order returns a fixed number of cycles after each request.
  initial begin
    pend_t p;
    imem_rd_valid = 1'b0;
    imem_rd_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (imem_rd_req === 1'b1) begin
        n_req++;
        got_addr.push_back(imem_rd_addr);
        got_cyc.push_back(cyc);
        p.due  = cyc + lat;
        p.data = mem_word(blk_tag, int'(imem_rd_addr));
        pend.push_back(p);
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        imem_rd_valid = 1'b1;
        imem_rd_data  = p.data;
      end else begin
        imem_rd_valid = 1'b0;
        imem_rd_data  = '0;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted instruction.
  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_inst: got=%0h exp=none", inst_data);
      end else begin
        chk("inst_data", inst_data, exp_q.pop_front());
      end
    end
    if (imem_rd_block_done === 1'b1) done_cnt++;
  end

  task automatic start_run();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs one block to completion; hold>0 stalls the decoder for that many cycles first.
  task automatic do_block(input int n, input bit lb, input logic [7:0] tag, input int hold);
    int n0;
    int d0;
    int k;
    bit seen;
    n0 = n_req;
    d0 = done_cnt;
    blk_tag = tag;
    got_addr.delete();
    got_cyc.delete();
    block_num_inst = 11'(n);
    last_block = lb;
    for (int i = 0; i < n; i++) exp_q.push_back(mem_word(tag, i));
    if (hold > 0) inst_ready = 1'b0;
    imem_block_ready = 1'b1;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("bp_req_count", n_req - n0, DEPTH);
      chk("bp_ovf", ovf_err, 0);
      @(posedge clk); #1;
      inst_ready = 1'b1;
    end
    seen = 1'b0;
    k = 0;
    while (!seen && k < 400) begin
      @(negedge clk);
      k++;
      if (imem_rd_block_done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got=none exp=pulse");
    end
    @(posedge clk); #1;
    imem_block_ready = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("req_count", n_req - n0, n);
    for (int i = 0; i < n; i++)
      chk("rd_addr", (i < got_addr.size()) ? 32'(got_addr[i]) : 32'hFFFF_FFFF, i);
    repeat (2) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    int n0;
    int d0;
    int k;
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    block_num_inst = '0;
    last_block = 1'b0;
    flush = 1'b0;
    imem_block_ready = 1'b0;
    inst_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", imem_rd_req, 0);
    chk("rst_addr", imem_rd_addr, 0);
    chk("rst_done", imem_rd_block_done, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_ovf", ovf_err, 0);
    reset = 1'b0;

    // Basic block: 8 words, latency 2, back-to-back requests.
    lat = 2;
    start_run();
    do_block(8, 1'b1, 8'hA1, 0);
    chk("b2b_span", (got_cyc.size() == 8) ? 32'(got_cyc[7] - got_cyc[0]) : 32'hFFFF_FFFF, 7);
    chk("idle_after_basic", fetch_busy, 0);

    // Backpressure: decoder stalled for 20 cycles.
    start_run();
    do_block(8, 1'b1, 8'hB2, 20);
    chk("bp_ovf_after", ovf_err, 0);

    // Multi-block: addresses restart for the second block.
    start_run();
    do_block(3, 1'b0, 8'hC3, 0);
    chk("busy_between_blocks", fetch_busy, 1);
    do_block(5, 1'b1, 8'hC4, 0);
    chk("idle_after_multi", fetch_busy, 0);

    // Zero-length block: done the cycle after ready is sampled, no requests.
    start_run();
    n0 = n_req;
    block_num_inst = '0;
    last_block = 1'b1;
    imem_block_ready = 1'b1;
    @(negedge clk);
    chk("zero_done_early", imem_rd_block_done, 0);
    @(negedge clk);
    chk("zero_done", imem_rd_block_done, 1);
    @(posedge clk); #1;
    imem_block_ready = 1'b0;
    @(negedge clk);
    chk("zero_done_once", imem_rd_block_done, 0);
    chk("zero_no_req", n_req - n0, 0);
    chk("zero_idle", fetch_busy, 0);

    // Flush after two requests with latency 3: everything in flight is discarded.
    lat = 3;
    start_run();
    n0 = n_req;
    d0 = done_cnt;
    blk_tag = 8'hD5;
    block_num_inst = 11'd8;
    last_block = 1'b1;
    imem_block_ready = 1'b1;
    k = 0;
    while (n_req - n0 < 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 50) begin
      @(negedge clk);
      k++;
      chk("flush_valid", inst_valid, 0);
      if (imem_rd_block_done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL flush_done_timeout: got=none exp=pulse");
    end
    @(posedge clk); #1;
    imem_block_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("flush_valid_after", inst_valid, 0);
    chk("flush_req_count", n_req - n0, 3);
    chk("flush_done_pulses", done_cnt - d0, 1);
    chk("flush_idle", fetch_busy, 0);

    // Reset mid-FETCH with words buffered and reads still in flight.
    lat = 3;
    inst_ready = 1'b0;
    start_run();
    blk_tag = 8'hE6;
    block_num_inst = 11'd8;
    last_block = 1'b1;
    imem_block_ready = 1'b1;
    k = 0;
    while (inst_valid !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("pre_rst_valid", inst_valid, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    imem_block_ready = 1'b0;
    inst_ready = 1'b1;
    chk("mid_rst_req", imem_rd_req, 0);
    chk("mid_rst_addr", imem_rd_addr, 0);
    chk("mid_rst_done", imem_rd_block_done, 0);
    chk("mid_rst_valid", inst_valid, 0);
    chk("mid_rst_data", inst_data, 0);
    chk("mid_rst_busy", fetch_busy, 0);
    chk("mid_rst_ovf", ovf_err, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("late_valid", inst_valid, 0);
    end
    chk("late_busy", fetch_busy, 0);
    chk("final_exp_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
